// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM states and
// default sizing constants.
package mult_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W_DEF = $clog2(WIDTH_DEF) + 1;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CALCULA = 2'd1,
    FIM     = 2'd2
  } state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/multiplicador_seq.sv
// Shift-add multiplier, one partial product per clock; product held until the
// next completion. Define MULT_SIGNED_EN for two's-complement operands.
//
// state   | meaning
// OCIOSO  | idle, waiting for inicio
// CALCULA | one add/shift iteration per edge, WIDTH iterations
// FIM     | product just written, pronto high for one cycle
module multiplicador_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inicio,
  input  logic [WIDTH-1:0] operando1,
  input  logic [WIDTH-1:0] operando2,
  output logic [WIDTH-1:0] res_low,
  output logic [WIDTH-1:0] res_high,
  output logic             ocupado,
  output logic             pronto
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_mult;
  logic [WIDTH:0]       r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*WIDTH-1:0]   r_res;
  logic                 r_ocupado;
  logic                 r_pronto;

  logic                 w_start;
  logic                 w_last;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_prod;
  logic [2*WIDTH-1:0]   w_res;
  logic [WIDTH-1:0]     w_mag1;
  logic [WIDTH-1:0]     w_mag2;
  logic                 w_ocupado_nxt;
  logic                 w_pronto_nxt;
  logic                 w_load_res;

  assign w_start = (r_state == OCIOSO) && inicio;
  assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_sum   = r_acc + (r_mult[0] ? {1'b0, r_mcand} : '0);
  // Final iteration's shifted pair, so the product is ready on the FIM edge
  assign w_prod  = {w_sum, r_mult[WIDTH-1:1]};

`ifdef MULT_SIGNED_EN
  logic r_neg;

  // Magnitude of the most-negative value is exact when read as unsigned
  assign w_mag1 = operando1[WIDTH-1] ? (~operando1 + WIDTH'(1)) : operando1;
  assign w_mag2 = operando2[WIDTH-1] ? (~operando2 + WIDTH'(1)) : operando2;
  assign w_res  = r_neg ? (~w_prod + (2*WIDTH)'(1)) : w_prod;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_neg <= 1'b0;
    end else if (w_start) begin
      r_neg <= operando1[WIDTH-1] ^ operando2[WIDTH-1];
    end
  end
`else
  assign w_mag1 = operando1;
  assign w_mag2 = operando2;
  assign w_res  = w_prod;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= OCIOSO;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      OCIOSO:  if (inicio) w_state_nxt = CALCULA;
      CALCULA: if (w_last) w_state_nxt = FIM;
      FIM:     w_state_nxt = OCIOSO;
      default: w_state_nxt = OCIOSO;
    endcase
  end

  always_comb begin
    w_ocupado_nxt = (w_state_nxt == CALCULA);
    w_pronto_nxt  = (w_state_nxt == FIM);
    w_load_res    = (r_state == CALCULA) && w_last;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mcand <= '0;
      r_mult  <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (w_start) begin
      r_mcand <= w_mag1;
      r_mult  <= w_mag2;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (r_state == CALCULA) begin
      r_acc   <= {1'b0, w_sum[WIDTH:1]};
      r_mult  <= {w_sum[0], r_mult[WIDTH-1:1]};
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_res     <= '0;
      r_ocupado <= 1'b0;
      r_pronto  <= 1'b0;
    end else begin
      r_ocupado <= w_ocupado_nxt;
      r_pronto  <= w_pronto_nxt;
      if (w_load_res) r_res <= w_res;
    end
  end

  assign res_low  = r_res[WIDTH-1:0];
  assign res_high = r_res[2*WIDTH-1:WIDTH];
  assign ocupado  = r_ocupado;
  assign pronto   = r_pronto;

endmodule

// File: tb/tb_multiplicador_seq.sv
// Randomized self-checking bench for multiplicador_seq against an arithmetic
// reference; honours MULT_SIGNED_EN the same way as the design.
module tb_multiplicador_seq;

  localparam int W = 16;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         inicio = 1'b0;
  logic [W-1:0] operando1 = '0;
  logic [W-1:0] operando2 = '0;
  logic [W-1:0] res_low;
  logic [W-1:0] res_high;
  logic         ocupado;
  logic         pronto;

  int          n_checks = 0;
  int          n_err = 0;
  logic [31:0] last_exp = '0;

  multiplicador_seq #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .inicio(inicio),
    .operando1(operando1), .operando2(operando2),
    .res_low(res_low), .res_high(res_high),
    .ocupado(ocupado), .pronto(pronto)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULT_SIGNED_EN
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[31:0];
`else
    return {16'b0, a} * {16'b0, b};
`endif
  endfunction

  // glitch_at >= 0 pulses a competing start (0x0010*0x0010) mid-operation
  task automatic do_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [31:0] exp, input string tag, input int glitch_at);
    int busy = 0;
    int lat = -1;
    logic hold_ok = 1'b1;
    logic both = 1'b0;
    @(negedge clock);
    operando1 = a; operando2 = b; inicio = 1'b1;
    @(posedge clock);
    #1;
    inicio = 1'b0; operando1 = W'($urandom); operando2 = W'($urandom);
    for (int c = 0; c < 100 && lat < 0; c++) begin
      @(negedge clock);
      if (ocupado && pronto) both = 1'b1;
      if (pronto) lat = c;
      else begin
        if (ocupado) busy++;
        if ({res_high, res_low} !== last_exp) hold_ok = 1'b0;
      end
      if (glitch_at >= 0 && c == glitch_at) begin
        operando1 = 16'h0010; operando2 = 16'h0010; inicio = 1'b1;
      end else begin
        inicio = 1'b0;
      end
    end
    check({tag, "_lat"}, 32'(lat), 32'(W));
    check({tag, "_busy"}, 32'(busy), 32'(W));
    check({tag, "_prod"}, {res_high, res_low}, exp);
    check({tag, "_hold"}, 32'(hold_ok), 32'd1);
    check({tag, "_excl"}, 32'(both), 32'd0);
    @(negedge clock);
    check({tag, "_pulse"}, {30'b0, pronto, ocupado}, 32'd0);
    last_exp = exp;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int npr, npulse, prevk, firstk;

    #13;
    check("rst_res", {res_high, res_low}, 32'd0);
    check("rst_flags", {30'b0, pronto, ocupado}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    do_mult(16'h0003, 16'h0005, 32'h0000_000F, "3x5", -1);
`ifdef MULT_SIGNED_EN
    do_mult(16'hFFFF, 16'hFFFF, 32'h0000_0001, "ffff", -1);
`else
    do_mult(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, "ffff", -1);
`endif
    do_mult(16'h0000, 16'h1234, 32'h0000_0000, "zero", -1);
    do_mult(16'h0002, 16'h0003, 32'h0000_0006, "ignored", 5);
    do_mult(16'h0010, 16'h0010, 32'h0000_0100, "after_ign", -1);

    // Reset in the middle of an operation after a 0x000F product
    do_mult(16'h0003, 16'h0005, 32'h0000_000F, "pre_rst", -1);
    @(negedge clock);
    operando1 = 16'h1234; operando2 = 16'h5678; inicio = 1'b1;
    @(negedge clock);
    inicio = 1'b0;
    repeat (7) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("midrst_res", {res_high, res_low}, 32'd0);
    check("midrst_flags", {30'b0, pronto, ocupado}, 32'd0);
    last_exp = '0;
    @(negedge clock);
    reset = 1'b0;
    npr = 0;
    repeat (W + 4) begin
      @(negedge clock);
      if (pronto) npr++;
    end
    check("midrst_nopronto", 32'(npr), 32'd0);
    do_mult(16'h0007, 16'h0009, 32'h0000_003F, "post_rst", -1);

    // inicio held high: a new product every W+2 cycles
    @(negedge clock);
    operando1 = 16'h0004; operando2 = 16'h0004; inicio = 1'b1;
    npulse = 0; prevk = 0; firstk = -1;
    for (int k = 0; k < 4 * (W + 2); k++) begin
      @(negedge clock);
      if (pronto) begin
        if (npulse == 0) firstk = k;
        else check("b2b_period", 32'(k - prevk), 32'(W + 2));
        check("b2b_prod", {res_high, res_low}, 32'h0000_0010);
        prevk = k;
        npulse++;
      end
    end
    inicio = 1'b0;
    check("b2b_first", 32'(firstk), 32'(W));
    check("b2b_count", 32'(npulse), 32'd4);
    repeat (W + 4) @(negedge clock);
    last_exp = 32'h0000_0010;

`ifdef MULT_SIGNED_EN
    do_mult(16'hFFFE, 16'h0003, 32'hFFFF_FFFA, "fffe_x3", -1);
`else
    do_mult(16'hFFFE, 16'h0003, 32'h0002_FFFA, "fffe_x3", -1);
`endif
    do_mult(16'h8000, 16'h8000, 32'h4000_0000, "minneg", -1);

    for (int i = 0; i < 12; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      do_mult(ra, rb, model(ra, rb), "rand", -1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
